alu_result_tx: RTL and testbench

Serial transmitter that takes an 8-bit parallel result, such as the registered ALU output, and sends it out on a single line as an asynchronous frame: start bit, data LSB-first, optional even parity, stop bit. The parallel side receives results one word at a time through a valid/ready handshake. The serial side drives one line, bit-timed by an internal divider. The block sits at the output of the ALU datapath and turns the captured register value back into an external serial stream for the lab board/host.

---
 rtl/alu_result_tx.sv | 131 +++++++++++++
 tb/tb_alu_result_tx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_result_tx.sv
// alu_result_tx: serialises an accepted parallel word as start, LSB-first data, optional even parity, stop.
// Define ALU_TX_PARITY_EN to include the parity bit.
module alu_result_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ALU_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
`ifdef ALU_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef ALU_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (din_valid) begin
                state_d = START;
                shift_d = din;
                cnt_d   = RELOAD;
                tx_d    = 1'b0;
`ifdef ALU_TX_PARITY_EN
                par_d   = ^din;
`endif
            end
            START: if (cnt_q == '0) begin
                state_d = DATA;
                idx_d   = '0;
                cnt_d   = RELOAD;
                tx_d    = shift_q[0];
            end
            DATA: if (cnt_q == '0) begin
                cnt_d = RELOAD;
                if (idx_q == LAST) begin
`ifdef ALU_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    tx_d    = shift_d[0];
                end
            end
`ifdef ALU_TX_PARITY_EN
            PARITY: if (cnt_q == '0) begin
                state_d = STOP;
                cnt_d   = RELOAD;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (cnt_q == '0) begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // done marks the final cycle of the stop bit, so it is decoded from the next state
        done_d = (state_d == STOP) && (cnt_d == '0);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef ALU_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign din_ready = (state_q == IDLE);
    assign tx        = tx_q;
    assign done      = done_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_alu_result_tx.sv
// tb_alu_result_tx: directed checks of frame shape, timing, reset abort and back-to-back words.
module tb_alu_result_tx;
    localparam int C = 4;
`ifdef ALU_TX_PARITY_EN
    localparam int N = 11;
`else
    localparam int N = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, tx, busy, done;
    int         tests = 0;
    int         fails = 0;

    alu_result_tx #(.DATA_W(8), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (N == 11 && b == 9) return ^w;
        return 1'b1;
    endfunction

    // Caller sets din/din_valid at a negedge; the next posedge is the accepting edge.
    // Checks every cycle of the frame plus the idle cycle after it.
    task automatic frame(input logic [7:0] w, input bit drop, input logic [7:0] din_next);
        chk("rdy_pre", din_ready, 1);
        @(posedge clk);
        #1;
        din = din_next;
        if (drop) din_valid = 1'b0;
        for (int j = 1; j <= N * C; j++) begin
            @(negedge clk);
            chk($sformatf("tx_%h_c%0d", w, j), tx, frame_bit(w, (j - 1) / C));
            chk($sformatf("done_%h_c%0d", w, j), done, (j == N * C));
            chk($sformatf("busy_%h_c%0d", w, j), busy, 1);
            chk($sformatf("rdy_%h_c%0d", w, j), din_ready, 0);
        end
        @(negedge clk);
        chk("rdy_post", din_ready, 1);
        chk("tx_idle_post", tx, 1);
        chk("done_post", done, 0);
        chk("busy_post", busy, 0);
    endtask

    initial begin
        reset = 1'b0;
        din = 8'($urandom);
        din_valid = 1'b1;
        #100;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", din_ready, 1);
        @(negedge clk);
        din_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);

        din = 8'hA5;
        din_valid = 1'b1;
        frame(8'hA5, 1, 8'h00);

`ifdef ALU_TX_PARITY_EN
        @(negedge clk);
        din = 8'h07;
        din_valid = 1'b1;
        frame(8'h07, 1, 8'h00);
        @(negedge clk);
        din = 8'h03;
        din_valid = 1'b1;
        frame(8'h03, 1, 8'h00);
`endif

        @(negedge clk);
        din = 8'h3C;
        din_valid = 1'b1;
        frame(8'h3C, 0, 8'hFF);
        din_valid = 1'b0;
        @(negedge clk);
        chk("stab_no_accept", busy, 0);

        din = 8'hC3;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (4 * C + 2) @(negedge clk);
        chk("mid_tx_bit3", tx, 0);
        chk("mid_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        for (int j = 0; j < 3 * C; j++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_done_%0d", j), done, 0);
        end
        reset = 1'b1;
        for (int j = 0; j < 2 * C; j++) begin
            @(negedge clk);
            chk($sformatf("mid_after_tx_%0d", j), tx, 1);
            chk($sformatf("mid_after_done_%0d", j), done, 0);
        end
        din = 8'h5A;
        din_valid = 1'b1;
        frame(8'h5A, 1, 8'h00);

        @(negedge clk);
        din = 8'h01;
        din_valid = 1'b1;
        frame(8'h01, 0, 8'h80);
        frame(8'h80, 1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
